// File: rtl/csr_pkg.sv
// csr_pkg
// Purpose: shared CSR-operation encoding used by the commit decoder, the
//          commit control unit and the CSR unit.
// Contents: csr_op_t (CSR_OP_NONE means "no CSR access").
package csr_pkg;

  typedef enum logic [2:0] {
    CSR_OP_NONE   = 3'd0,
    CSR_OP_CSRRW  = 3'd1,
    CSR_OP_CSRRS  = 3'd2,
    CSR_OP_CSRRC  = 3'd3,
    CSR_OP_CSRRWI = 3'd4,
    CSR_OP_CSRRSI = 3'd5,
    CSR_OP_CSRRCI = 3'd6
  } csr_op_t;

endpackage : csr_pkg

// File: rtl/expipe_pkg.sv
// expipe_pkg
// Purpose: execution-pipeline types shared by the commit decoder and the
//          commit control unit.
// Contents: comm_type_t  - retirement class of the ROB head instruction
//           commit_state_t - commit sequencer states
package expipe_pkg;

  typedef enum logic [3:0] {
    NONE      = 4'd0,
    INT_RF    = 4'd1,
    FP_RF     = 4'd2,
    INT_RF_FP = 4'd3,
    LOAD      = 4'd4,
    LOAD_FP   = 4'd5,
    STORE     = 4'd6,
    BRANCH    = 4'd7,
    JUMP      = 4'd8,
    CSR       = 4'd9,
    FENCE     = 4'd10,
    MRET      = 4'd11,
    WFI       = 4'd12,
    ECALL     = 4'd13,
    EBREAK    = 4'd14,
    EXCEPT    = 4'd15
  } comm_type_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FENCE = 2'd1,
    S_WFI   = 2'd2,
    S_FLUSH = 2'd3
  } commit_state_t;

endpackage : expipe_pkg

// File: rtl/commit_cu.sv
// commit_cu
// Purpose: commit control unit. Sequences retirement of the ROB head based
//          on its commit class and CSR op, and raises register-file writes,
//          store commits, CSR requests, trap/mret requests, pipeline flushes
//          and the retire pulse.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   comm_valid_i / comm_ready_o  ROB head valid / head popped this cycle
//   comm_type_i, csr_op_i        decoder classification and CSR op of head
//   mispredict_i                 head branch/jump was mispredicted
//   int_rf_we_o, fp_rf_we_o      register-file write enables
//   csr_valid_o, csr_op_o        CSR request, csr_ready_i accepts it
//   sb_commit_o, sb_empty_i      store-buffer commit / drained indication
//   except_o, mret_o             trap and mret request pulses
//   irq_pending_i                interrupt pending (wakes WFI)
//   flush_o                      pipeline flush (held FLUSH_CYCLES cycles)
//   retire_o                     instruction retired
module commit_cu
  import expipe_pkg::*;
  import csr_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       comm_valid_i,
  output logic       comm_ready_o,
  input  comm_type_t comm_type_i,
  input  csr_op_t    csr_op_i,
  input  logic       mispredict_i,
  output logic       int_rf_we_o,
  output logic       fp_rf_we_o,
  output logic       csr_valid_o,
  output csr_op_t    csr_op_o,
  input  logic       csr_ready_i,
  output logic       sb_commit_o,
  input  logic       sb_empty_i,
  output logic       except_o,
  output logic       mret_o,
  input  logic       irq_pending_i,
  output logic       flush_o,
  output logic       retire_o
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

  commit_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state and output decode. Outputs are Mealy in S_IDLE/S_FENCE and
  // only flush_o is driven in S_FLUSH. Everything is gated by rst_i so that
  // a head presented during reset cannot leak a commit or a CSR request.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    comm_ready_o = 1'b0;
    int_rf_we_o  = 1'b0;
    fp_rf_we_o   = 1'b0;
    csr_valid_o  = 1'b0;
    csr_op_o     = CSR_OP_NONE;
    sb_commit_o  = 1'b0;
    except_o     = 1'b0;
    mret_o       = 1'b0;
    flush_o      = 1'b0;
    retire_o     = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_IDLE: begin
          if (comm_valid_i) begin
            case (comm_type_i)
              INT_RF, LOAD: begin
                comm_ready_o = 1'b1;
                int_rf_we_o  = 1'b1;
                retire_o     = 1'b1;
              end
              LOAD_FP: begin
                comm_ready_o = 1'b1;
                fp_rf_we_o   = 1'b1;
                retire_o     = 1'b1;
              end
              // FP ops carry an fflags update, so the head only retires
              // once the CSR unit has taken that update.
              FP_RF, INT_RF_FP: begin
                csr_valid_o = 1'b1;
                csr_op_o    = csr_op_i;
                if (csr_ready_i) begin
                  comm_ready_o = 1'b1;
                  retire_o     = 1'b1;
                  fp_rf_we_o   = (comm_type_i == FP_RF);
                  int_rf_we_o  = (comm_type_i == INT_RF_FP);
                end
              end
              STORE: begin
                comm_ready_o = 1'b1;
                sb_commit_o  = 1'b1;
                retire_o     = 1'b1;
              end
              BRANCH, JUMP: begin
                comm_ready_o = 1'b1;
                retire_o     = 1'b1;
                int_rf_we_o  = (comm_type_i == JUMP);
                if (mispredict_i) state_d = S_FLUSH;
              end
              CSR: begin
                csr_valid_o = 1'b1;
                csr_op_o    = csr_op_i;
                if (csr_ready_i) begin
                  comm_ready_o = 1'b1;
                  int_rf_we_o  = 1'b1;
                  retire_o     = 1'b1;
                  state_d      = S_FLUSH;
                end
              end
              FENCE: state_d = S_FENCE;
              MRET: begin
                mret_o       = 1'b1;
                comm_ready_o = 1'b1;
                retire_o     = 1'b1;
                state_d      = S_FLUSH;
              end
              WFI: begin
                comm_ready_o = 1'b1;
                retire_o     = 1'b1;
                state_d      = S_WFI;
              end
              // Traps pop the head without retiring it.
              ECALL, EBREAK, EXCEPT: begin
                except_o     = 1'b1;
                comm_ready_o = 1'b1;
                state_d      = S_FLUSH;
              end
              default: ;
            endcase
          end
        end
        S_FENCE: begin
          if (sb_empty_i) begin
            comm_ready_o = 1'b1;
            retire_o     = 1'b1;
            state_d      = S_FLUSH;
          end
        end
        S_WFI: begin
          if (irq_pending_i) state_d = S_FLUSH;
        end
        S_FLUSH: begin
          flush_o = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and flush counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : commit_cu

// File: tb/tb_commit_cu.sv
// tb_commit_cu
// Purpose: self-checking bench for commit_cu with FLUSH_CYCLES = 3.
// A cycle-level reference model in the compare process predicts every output
// each cycle; a few literal checks in the stimulus pin the model itself.
module tb_commit_cu;
  import expipe_pkg::*;
  import csr_pkg::*;

  localparam int FC = 3;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       comm_valid_i;
  logic       comm_ready_o;
  comm_type_t comm_type_i;
  csr_op_t    csr_op_i;
  logic       mispredict_i;
  logic       int_rf_we_o;
  logic       fp_rf_we_o;
  logic       csr_valid_o;
  csr_op_t    csr_op_o;
  logic       csr_ready_i;
  logic       sb_commit_o;
  logic       sb_empty_i;
  logic       except_o;
  logic       mret_o;
  logic       irq_pending_i;
  logic       flush_o;
  logic       retire_o;

  int  vectorCount = 0;
  int  failCount   = 0;
  bit  checkEn     = 1'b0;

  // Reference model state: cycles of flush still owed, and whether the
  // machine is parked waiting on a fence drain or an interrupt.
  int  flushLeft = 0;
  bit  fenceWait = 1'b0;
  bit  wfiWait   = 1'b0;

  logic    eReady, eInt, eFp, eCsrV, eSb, eExc, eMret, eFlush, eRetire;
  csr_op_t eCsrOp;

  commit_cu #(.FLUSH_CYCLES(FC)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .comm_valid_i (comm_valid_i),
    .comm_ready_o (comm_ready_o),
    .comm_type_i  (comm_type_i),
    .csr_op_i     (csr_op_i),
    .mispredict_i (mispredict_i),
    .int_rf_we_o  (int_rf_we_o),
    .fp_rf_we_o   (fp_rf_we_o),
    .csr_valid_o  (csr_valid_o),
    .csr_op_o     (csr_op_o),
    .csr_ready_i  (csr_ready_i),
    .sb_commit_o  (sb_commit_o),
    .sb_empty_i   (sb_empty_i),
    .except_o     (except_o),
    .mret_o       (mret_o),
    .irq_pending_i(irq_pending_i),
    .flush_o      (flush_o),
    .retire_o     (retire_o)
  );

  always #5 clk_i = ~clk_i;

  // One comparison: counts it, reports a miscompare on a single line.
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectorCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Predict this cycle's outputs from the current inputs and model state,
  // then advance the model to what the next cycle will look like.
  task automatic modelStep();
    eReady = 0; eInt = 0; eFp = 0; eCsrV = 0; eSb = 0;
    eExc = 0; eMret = 0; eFlush = 0; eRetire = 0; eCsrOp = CSR_OP_NONE;
    if (rst_i) begin
      flushLeft = 0; fenceWait = 0; wfiWait = 0;
    end else if (flushLeft > 0) begin
      eFlush = 1;
      flushLeft--;
    end else if (wfiWait) begin
      if (irq_pending_i) begin
        wfiWait = 0; flushLeft = FC;
      end
    end else if (fenceWait) begin
      if (sb_empty_i) begin
        eReady = 1; eRetire = 1; fenceWait = 0; flushLeft = FC;
      end
    end else if (comm_valid_i) begin
      case (comm_type_i)
        INT_RF, LOAD: begin eReady = 1; eRetire = 1; eInt = 1; end
        LOAD_FP:      begin eReady = 1; eRetire = 1; eFp = 1; end
        FP_RF, INT_RF_FP: begin
          eCsrV = 1; eCsrOp = csr_op_i;
          if (csr_ready_i) begin
            eReady = 1; eRetire = 1;
            if (comm_type_i == FP_RF) eFp = 1; else eInt = 1;
          end
        end
        STORE: begin eReady = 1; eRetire = 1; eSb = 1; end
        BRANCH, JUMP: begin
          eReady = 1; eRetire = 1; eInt = (comm_type_i == JUMP);
          if (mispredict_i) flushLeft = FC;
        end
        CSR: begin
          eCsrV = 1; eCsrOp = csr_op_i;
          if (csr_ready_i) begin
            eReady = 1; eRetire = 1; eInt = 1; flushLeft = FC;
          end
        end
        FENCE: fenceWait = 1;
        MRET:  begin eReady = 1; eRetire = 1; eMret = 1; flushLeft = FC; end
        WFI:   begin eReady = 1; eRetire = 1; wfiWait = 1; end
        ECALL, EBREAK, EXCEPT: begin eReady = 1; eExc = 1; flushLeft = FC; end
        default: ;
      endcase
    end
  endtask

  // Compare every output against the model once per cycle, mid-cycle.
  always @(negedge clk_i) begin
    if (checkEn) begin
      modelStep();
      checkOutput("comm_ready", comm_ready_o, eReady);
      checkOutput("int_rf_we",  int_rf_we_o,  eInt);
      checkOutput("fp_rf_we",   fp_rf_we_o,   eFp);
      checkOutput("csr_valid",  csr_valid_o,  eCsrV);
      checkOutput("csr_op",     8'(csr_op_o), 8'(eCsrOp));
      checkOutput("sb_commit",  sb_commit_o,  eSb);
      checkOutput("except",     except_o,     eExc);
      checkOutput("mret",       mret_o,       eMret);
      checkOutput("flush",      flush_o,      eFlush);
      checkOutput("retire",     retire_o,     eRetire);
    end
  end

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input bit r, input bit v, input comm_type_t t,
                               input csr_op_t op, input bit mp, input bit cr,
                               input bit sb, input bit irq);
    @(posedge clk_i);
    #1;
    rst_i = r; comm_valid_i = v; comm_type_i = t; csr_op_i = op;
    mispredict_i = mp; csr_ready_i = cr; sb_empty_i = sb; irq_pending_i = irq;
  endtask

  task automatic head(input comm_type_t t);
    applyStimulus(0, 1, t, CSR_OP_NONE, 0, 1, 1, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, NONE, CSR_OP_NONE, 0, 0, 1, 0);
  endtask

  initial begin
    rst_i = 1; comm_valid_i = 0; comm_type_i = NONE; csr_op_i = CSR_OP_NONE;
    mispredict_i = 0; csr_ready_i = 0; sb_empty_i = 1; irq_pending_i = 0;
    checkEn = 1;

    // Reset with a committable head present: nothing may leak out.
    applyStimulus(1, 1, INT_RF, CSR_OP_NONE, 0, 1, 1, 0);
    applyStimulus(1, 1, INT_RF, CSR_OP_NONE, 0, 1, 1, 0);
    #2 checkOutput("lit_reset_ready", comm_ready_o, 0);
    checkOutput("lit_reset_we", int_rf_we_o, 0);
    idle(1);

    // Simple single-cycle commits.
    head(INT_RF);
    #2 checkOutput("lit_add_ready", comm_ready_o, 1);
    checkOutput("lit_add_we", int_rf_we_o, 1);
    checkOutput("lit_add_retire", retire_o, 1);
    head(LOAD);
    applyStimulus(0, 1, FP_RF, CSR_OP_CSRRS, 0, 1, 1, 0);
    #2 checkOutput("lit_fp_we", fp_rf_we_o, 1);
    checkOutput("lit_fp_csrop", 8'(csr_op_o), 8'(CSR_OP_CSRRS));
    head(LOAD_FP);
    head(STORE);
    #2 checkOutput("lit_store_sb", sb_commit_o, 1);
    applyStimulus(0, 1, INT_RF_FP, CSR_OP_CSRRC, 0, 0, 1, 0);
    #2 checkOutput("lit_irfp_hold", comm_ready_o, 0);
    applyStimulus(0, 1, INT_RF_FP, CSR_OP_CSRRC, 0, 1, 1, 0);
    head(BRANCH);
    head(JUMP);
    #2 checkOutput("lit_jump_we", int_rf_we_o, 1);
    head(NONE);
    #2 checkOutput("lit_none_ready", comm_ready_o, 0);

    // CSR head stalled three cycles on the CSR unit.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, CSR, CSR_OP_CSRRW, 0, 0, 1, 0);
      #2 checkOutput("lit_csr_wait_valid", csr_valid_o, 1);
      checkOutput("lit_csr_wait_ready", comm_ready_o, 0);
    end
    applyStimulus(0, 1, CSR, CSR_OP_CSRRW, 0, 1, 1, 0);
    #2 checkOutput("lit_csr_pop", comm_ready_o, 1);
    idle(1);
    #2 checkOutput("lit_csr_flush", flush_o, 1);
    idle(FC - 1);
    head(INT_RF);
    #2 checkOutput("lit_post_csr_ready", comm_ready_o, 1);

    // Mispredicted branch: three flush cycles with a waiting head.
    applyStimulus(0, 1, BRANCH, CSR_OP_NONE, 1, 1, 1, 0);
    for (int i = 0; i < FC; i++) begin
      head(INT_RF);
      #2 checkOutput("lit_br_flush", flush_o, 1);
      checkOutput("lit_br_noready", comm_ready_o, 0);
    end
    head(INT_RF);
    #2 checkOutput("lit_br_after", comm_ready_o, 1);

    // Fence waits five cycles for the store buffer.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, FENCE, CSR_OP_NONE, 0, 1, 0, 0);
      #2 checkOutput("lit_fence_wait", comm_ready_o, 0);
    end
    applyStimulus(0, 1, FENCE, CSR_OP_NONE, 0, 1, 1, 0);
    #2 checkOutput("lit_fence_pop", retire_o, 1);
    idle(FC);

    // Traps and mret.
    head(ECALL);
    #2 checkOutput("lit_ecall_exc", except_o, 1);
    checkOutput("lit_ecall_noretire", retire_o, 0);
    idle(FC);
    head(EBREAK);
    idle(FC);
    head(EXCEPT);
    idle(FC);
    head(MRET);
    #2 checkOutput("lit_mret", mret_o, 1);
    idle(FC);

    // WFI parks until an interrupt, ignoring the head.
    head(WFI);
    #2 checkOutput("lit_wfi_retire", retire_o, 1);
    for (int i = 0; i < 4; i++) head(INT_RF);
    #2 checkOutput("lit_wfi_hold", comm_ready_o, 0);
    applyStimulus(0, 1, INT_RF, CSR_OP_NONE, 0, 1, 1, 1);
    idle(FC);
    #2 checkOutput("lit_wfi_flush", flush_o, 1);
    idle(1);

    // Reset in the middle of a flush sequence.
    applyStimulus(0, 1, BRANCH, CSR_OP_NONE, 1, 1, 1, 0);
    idle(1);
    applyStimulus(1, 1, INT_RF, CSR_OP_NONE, 0, 1, 1, 0);
    #1 checkOutput("lit_rst_flush", flush_o, 0);
    checkOutput("lit_rst_ready", comm_ready_o, 0);
    head(INT_RF);
    #2 checkOutput("lit_rst_after", comm_ready_o, 1);
    idle(2);

    @(posedge clk_i);
    checkEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule : tb_commit_cu

// File: doc/commit_cu.md
Name: commit_cu

Overview:
- Commit control unit: FSM that sequences retirement of the ROB head instruction, driven by the commit-type classification (expipe_pkg::comm_type_t) and the CSR operation produced by the commit decoder.
- Issues register-file write enables, store-commit, CSR requests, trap/mret requests, pipeline flushes and the retire pulse.
- Sits between the ROB head, the CSR unit, the store buffer and the front-end.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles flush_o is held after a flushing commit (legal range >=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- comm_valid_i  in  1  ROB head valid
- comm_ready_o  out  1  head consumed (pop) this cycle
- comm_type_i  in  comm_type_t  decoder classification of head
- csr_op_i  in  csr_op_t  decoder CSR op of head
- mispredict_i  in  1  head branch/jump was mispredicted
- int_rf_we_o  out  1  integer RF write enable
- fp_rf_we_o  out  1  FP RF write enable
- csr_valid_o  out  1  CSR request (valid)
- csr_op_o  out  csr_op_t  CSR op forwarded with request
- csr_ready_i  in  1  CSR unit accepts request
- sb_commit_o  out  1  mark head store committed in store buffer
- sb_empty_i  in  1  store buffer drained
- except_o  out  1  trap request (1-cycle pulse)
- mret_o  out  1  mret request (1-cycle pulse)
- irq_pending_i  in  1  enabled interrupt pending (WFI wake)
- flush_o  out  1  pipeline flush
- retire_o  out  1  instruction retired (minstret increment)

Behaviour:
- States: S_IDLE, S_FENCE, S_WFI, S_FLUSH. Reset -> S_IDLE, flush counter 0. All outputs 0 during and after reset until comm_valid_i.
- Outputs are Mealy in S_IDLE/S_FENCE; flush_o is Moore (high only in S_FLUSH).
- comm_ready_o is 0 in S_WFI and S_FLUSH. In S_IDLE, with comm_valid_i=0, all outputs are 0 and the state is held.
- S_IDLE, comm_valid_i=1, by comm_type_i:
  - INT_RF, LOAD: comm_ready_o, int_rf_we_o, retire_o same cycle; stay.
  - FP_RF, LOAD_FP: same with fp_rf_we_o.
  - INT_RF_FP: int_rf_we_o.
  - FP_RF and INT_RF_FP additionally assert csr_valid_o with csr_op_o=csr_op_i (fflags update). Commit only when csr_ready_i=1; otherwise all of ready/we/retire stay 0 and the head is held.
  - STORE: sb_commit_o, comm_ready_o, retire_o; stay.
  - BRANCH, JUMP: commit; if JUMP, also int_rf_we_o. If mispredict_i, -> S_FLUSH, else stay.
  - CSR: csr_valid_o, csr_op_o=csr_op_i. On csr_ready_i: commit, int_rf_we_o, retire_o, -> S_FLUSH. Otherwise hold.
  - FENCE: -> S_FENCE, no pop.
  - MRET: mret_o, commit, retire_o, -> S_FLUSH.
  - WFI: commit, retire_o, -> S_WFI.
  - ECALL, EBREAK, EXCEPT: except_o, comm_ready_o, no retire_o, no writes, -> S_FLUSH.
  - NONE: hold, no outputs.
- S_FENCE: wait until sb_empty_i=1, then commit + retire_o in that cycle -> S_FLUSH. If sb_empty_i is already 1 on the cycle after entry, total latency is 2 cycles.
- S_WFI: when irq_pending_i=1 -> S_FLUSH. comm_valid_i is ignored.
- S_FLUSH: flush_o=1. Counter increments each cycle; after FLUSH_CYCLES cycles -> S_IDLE with counter cleared. Counter width $clog2(FLUSH_CYCLES+1).
- Commit in cycle N -> flush_o high N+1 .. N+FLUSH_CYCLES; the next commit is possible at N+FLUSH_CYCLES+1.
- At most one instruction commits per cycle. except_o and mret_o are never asserted together.
- Asynchronous reset in any state -> S_IDLE immediately. In-flight CSR request is dropped (csr_valid_o=0).

Decomposition:
- commit_state_t enum (S_IDLE, S_FENCE, S_WFI, S_FLUSH) goes in expipe_pkg alongside comm_type_t.
- csr_op_t stays in csr_pkg.
- Flush counter is inline. No sub-module; the commit decoder is instantiated by the parent and feeds comm_type_i/csr_op_i.

Test Plan:
- Reset, then ADD head (INT_RF) valid -> same cycle comm_ready_o=1, int_rf_we_o=1, retire_o=1; state stays S_IDLE.
- CSR head, csr_op_i=CSR_OP_CSRRW, csr_ready_i low 3 cycles then high -> csr_valid_o high 4 cycles; pop/retire only in cycle 4; flush_o high cycle 5 (FLUSH_CYCLES=1); ready again cycle 6.
- BRANCH with mispredict_i=1, FLUSH_CYCLES=3 -> pop at N; flush_o high N+1..N+3; comm_ready_o=0 for those cycles.
- FENCE with sb_empty_i low 5 cycles then high -> no pop for 5 cycles; pop + retire when empty; then one flush cycle.
- ECALL -> except_o 1-cycle pulse, pop, retire_o=0, flush follows. WFI -> retire, hold in S_WFI until irq_pending_i=1, then flush.
- Assert rst_i while in S_FLUSH (counter=1 of 3) -> all outputs 0 immediately; after release, INT_RF head commits on first valid cycle.
